// File: rtl/aurora_rx_frame_filter.sv
// Store-and-forward CRC gate for the Aurora 64B/66B RX stream: whole frames are buffered
// speculatively and only published to the reader once the last beat reports a good CRC.
module aurora_rx_frame_filter #(
  parameter int DEPTH_LOG2      = 9,
  parameter int MAX_FRAME_BEATS = 256
) (
  input  logic        auMGTclkOut,
  input  logic        resetOut,
  input  logic [63:0] sAxiTdata,
  input  logic [7:0]  sAxiTkeep,
  input  logic        sAxiTlast,
  input  logic        sAxiTvalid,
  input  logic        crcValid,
  input  logic        crcPass,
  output logic [63:0] mAxiTdata,
  output logic [7:0]  mAxiTkeep,
  output logic        mAxiTlast,
  output logic        mAxiTvalid,
  input  logic        mAxiTready,
  input  logic        clearCounters,
  output logic [15:0] goodFrames,
  output logic [15:0] crcErrFrames,
  output logic [15:0] overflowFrames
);

  // state | meaning
  // SYNC  | after reset; discard until a tlast puts us on a frame boundary
  // IDLE  | between frames; next valid beat opens a frame
  // RECV  | mid-frame; beats written speculatively past wrCommit
  // DROP  | frame doomed (full or oversize); discard to tlast, then roll back
  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_RECV, ST_DROP} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] MAX_BEATS = DEPTH_LOG2'(MAX_FRAME_BEATS);

  state_t                state_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_commit_q, rd_ptr_q, beat_cnt_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_nxt;
  logic [72:0]           mem [DEPTH];
  logic [72:0]           s1_data_q;
  logic                  s1_valid_q;
  logic                  out_valid_q, out_last_q;
  logic [7:0]            out_keep_q;
  logic [63:0]           out_data_q;
  logic [15:0]           good_cnt_q, crc_cnt_q, ovf_cnt_q;
  logic [15:0]           good_cnt_d, crc_cnt_d, ovf_cnt_d;
  logic                  full, can_write, wr_en, good_inc, crc_inc, ovf_inc;
  logic                  rd_avail, out_load, s1_free, rd_issue;

  assign wr_ptr_nxt = wr_ptr_q + 1'b1;
  assign full       = (wr_ptr_nxt == rd_ptr_q);
  assign can_write  = !full && (beat_cnt_q < MAX_BEATS);

  always_comb begin
    wr_en    = 1'b0;
    good_inc = 1'b0;
    crc_inc  = 1'b0;
    ovf_inc  = 1'b0;
    if (sAxiTvalid) begin
      unique case (state_q)
        ST_IDLE, ST_RECV: begin
          wr_en = can_write;
          if (sAxiTlast) begin
            if (!can_write)             ovf_inc  = 1'b1;
            else if (crcValid && crcPass) good_inc = 1'b1;
            else                        crc_inc  = 1'b1;
          end
        end
        ST_DROP: ovf_inc = sAxiTlast;
        default: ;
      endcase
    end
  end

  always_ff @(posedge auMGTclkOut or posedge resetOut) begin
    if (resetOut) begin
      state_q     <= ST_SYNC;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      beat_cnt_q  <= '0;
    end else if (sAxiTvalid) begin
      unique case (state_q)
        ST_SYNC: if (sAxiTlast) state_q <= ST_IDLE;
        ST_IDLE, ST_RECV: begin
          if (sAxiTlast) begin
            beat_cnt_q <= '0;
            state_q    <= ST_IDLE;
            if (good_inc) begin
              wr_ptr_q    <= wr_ptr_nxt;
              wr_commit_q <= wr_ptr_nxt;
            end else begin
              wr_ptr_q <= wr_commit_q;
            end
          end else if (can_write) begin
            wr_ptr_q   <= wr_ptr_nxt;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            state_q    <= ST_RECV;
          end else begin
            state_q <= ST_DROP;
          end
        end
        ST_DROP: if (sAxiTlast) begin
          wr_ptr_q   <= wr_commit_q;
          beat_cnt_q <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  // Read pipeline: synchronous RAM read stage feeding the output register, so every
  // stage can advance on the same cycle and a ready sink sees one beat per clock.
  assign rd_avail = (rd_ptr_q != wr_commit_q);
  assign out_load = s1_valid_q && (!out_valid_q || mAxiTready);
  assign s1_free  = !s1_valid_q || out_load;
  assign rd_issue = s1_free && rd_avail;

  always_ff @(posedge auMGTclkOut) begin
    if (wr_en) mem[wr_ptr_q] <= {sAxiTlast, sAxiTkeep, sAxiTdata};
    if (rd_issue) s1_data_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge auMGTclkOut or posedge resetOut) begin
    if (resetOut) begin
      rd_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_keep_q  <= '0;
      out_data_q  <= '0;
    end else begin
      if (rd_issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (s1_free) s1_valid_q <= rd_avail;
      if (out_load) begin
        out_valid_q <= 1'b1;
        {out_last_q, out_keep_q, out_data_q} <= s1_data_q;
      end else if (mAxiTready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign mAxiTvalid = out_valid_q;
  assign mAxiTlast  = out_last_q;
  assign mAxiTkeep  = out_keep_q;
  assign mAxiTdata  = out_data_q;

  // Clear takes priority over a coincident increment.
  function automatic logic [15:0] sat_next(input logic [15:0] cnt, input logic inc,
                                           input logic clr);
    if (clr) return 16'd0;
    if (inc && cnt != 16'hFFFF) return cnt + 16'd1;
    return cnt;
  endfunction

  always_comb begin
    good_cnt_d = sat_next(good_cnt_q, good_inc, clearCounters);
    crc_cnt_d  = sat_next(crc_cnt_q, crc_inc, clearCounters);
    ovf_cnt_d  = sat_next(ovf_cnt_q, ovf_inc, clearCounters);
  end

  always_ff @(posedge auMGTclkOut or posedge resetOut) begin
    if (resetOut) begin
      good_cnt_q <= '0;
      crc_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign goodFrames     = good_cnt_q;
  assign crcErrFrames   = crc_cnt_q;
  assign overflowFrames = ovf_cnt_q;

endmodule

// File: tb/tb_aurora_rx_frame_filter.sv
// Directed bench for aurora_rx_frame_filter: a shallow FIFO instance (a) and a short
// max-frame instance (b) share one input stream; each has its own expected frames.
module tb_aurora_rx_frame_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] sAxiTdata = '0;
  logic [7:0]  sAxiTkeep = '0;
  logic        sAxiTlast = 1'b0, sAxiTvalid = 1'b0, crcValid = 1'b0, crcPass = 1'b0;
  logic        mAxiTready = 1'b0, clearCounters = 1'b0;

  logic [63:0] a_data, b_data;
  logic [7:0]  a_keep, b_keep;
  logic        a_last, b_last, a_valid, b_valid;
  logic [15:0] a_good, a_crc, a_ovf, b_good, b_crc, b_ovf;

  int n_vec = 0;
  int n_miss = 0;
  logic [72:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  bit   rdy_rand = 1'b0;
  logic rdy_force = 1'b0;

  always #5 clk = ~clk;

  aurora_rx_frame_filter #(.DEPTH_LOG2(4), .MAX_FRAME_BEATS(15)) dut_a (
    .auMGTclkOut(clk), .resetOut(rst),
    .sAxiTdata(sAxiTdata), .sAxiTkeep(sAxiTkeep), .sAxiTlast(sAxiTlast), .sAxiTvalid(sAxiTvalid),
    .crcValid(crcValid), .crcPass(crcPass),
    .mAxiTdata(a_data), .mAxiTkeep(a_keep), .mAxiTlast(a_last), .mAxiTvalid(a_valid),
    .mAxiTready(mAxiTready), .clearCounters(clearCounters),
    .goodFrames(a_good), .crcErrFrames(a_crc), .overflowFrames(a_ovf));

  aurora_rx_frame_filter #(.DEPTH_LOG2(5), .MAX_FRAME_BEATS(8)) dut_b (
    .auMGTclkOut(clk), .resetOut(rst),
    .sAxiTdata(sAxiTdata), .sAxiTkeep(sAxiTkeep), .sAxiTlast(sAxiTlast), .sAxiTvalid(sAxiTvalid),
    .crcValid(crcValid), .crcPass(crcPass),
    .mAxiTdata(b_data), .mAxiTkeep(b_keep), .mAxiTlast(b_last), .mAxiTvalid(b_valid),
    .mAxiTready(mAxiTready), .clearCounters(clearCounters),
    .goodFrames(b_good), .crcErrFrames(b_crc), .overflowFrames(b_ovf));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] mk_beat(input int fid, input int b, input bit last);
    logic [63:0] d;
    logic [7:0]  k;
    d = {8'hA5, 8'(fid), 16'hC0DE, 16'(b), 16'(fid * 3 + b)};
    k = last ? ((8'h01 << 3'(fid % 8)) | 8'h01) : 8'hFF;
    return {last, k, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input int fid, input bit cv, input bit cp,
                            input bit pass_a, input bit pass_b);
    logic [72:0] bt;
    for (int i = 0; i < n; i++) begin
      bt = mk_beat(fid, i, i == n - 1);
      {sAxiTlast, sAxiTkeep, sAxiTdata} = bt;
      sAxiTvalid = 1'b1;
      crcValid   = (i == n - 1) ? cv : 1'b1;
      crcPass    = (i == n - 1) ? cp : 1'b0;
      if (pass_a) exp_a.push_back(bt);
      if (pass_b) exp_b.push_back(bt);
      tick();
    end
    sAxiTvalid = 1'b0; sAxiTlast = 1'b0; crcValid = 1'b0; crcPass = 1'b0;
  endtask

  task automatic clr_counters();
    clearCounters = 1'b1;
    tick();
    clearCounters = 1'b0;
  endtask

  task automatic drain_and_compare(input string tag);
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;
    repeat (60) tick();
    chk({tag, " count_a"}, 128'(got_a.size()), 128'(exp_a.size()));
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      chk({tag, " beat_a"}, 128'(got_a[i]), 128'(exp_a[i]));
    chk({tag, " count_b"}, 128'(got_b.size()), 128'(exp_b.size()));
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      chk({tag, " beat_b"}, 128'(got_b[i]), 128'(exp_b[i]));
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  initial forever begin
    tick();
    mAxiTready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Transfers are taken at the negedge before the edge that completes them.
  initial begin
    logic [72:0] held;
    bit stall_a;
    held = '0;
    stall_a = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_a && a_valid) chk("hold_a", 128'({a_last, a_keep, a_data}), 128'(held));
      stall_a = a_valid && !mAxiTready;
      held    = {a_last, a_keep, a_data};
      if (a_valid && mAxiTready) got_a.push_back({a_last, a_keep, a_data});
      if (b_valid && mAxiTready) got_b.push_back({b_last, b_keep, b_data});
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst valid", 128'(a_valid), 128'(0));
    chk("rst last", 128'(a_last), 128'(0));
    chk("rst data", 128'({a_keep, a_data}), 128'(0));
    chk("rst cnt", 128'({a_good, a_crc, a_ovf}), 128'(0));
    rst = 1'b0;

    // Mid-frame release: the tail up to tlast is discarded silently.
    rdy_force = 1'b1;
    send_frame(4, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(4, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    drain_and_compare("sync");
    chk("sync good_a", 128'(a_good), 128'(1));
    chk("sync good_b", 128'(b_good), 128'(1));
    chk("sync crc_a", 128'(a_crc), 128'(0));

    clr_counters();
    chk("clear good_a", 128'(a_good), 128'(0));
    send_frame(3, 2, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(5, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(2, 4, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("crcbad crc_a", 128'(a_crc), 128'(1));
    chk("crcbad good_a", 128'(a_good), 128'(2));
    send_frame(4, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(1, 6, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("crcmiss crc_a", 128'(a_crc), 128'(2));
    chk("crcmiss crc_b", 128'(b_crc), 128'(2));
    chk("crcmiss good_a", 128'(a_good), 128'(3));
    drain_and_compare("crc");

    // Capacity of the 16-entry FIFO is 15 beats with the reader stalled.
    clr_counters();
    rdy_force = 1'b0;
    send_frame(20, 7, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cap20 ovf_a", 128'(a_ovf), 128'(1));
    chk("cap20 ovf_b", 128'(b_ovf), 128'(1));
    chk("cap20 valid_a", 128'(a_valid), 128'(0));
    send_frame(16, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cap16 ovf_a", 128'(a_ovf), 128'(2));
    send_frame(15, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("cap15 good_a", 128'(a_good), 128'(1));
    chk("cap15 ovf_a", 128'(a_ovf), 128'(2));
    chk("cap15 ovf_b", 128'(b_ovf), 128'(3));
    chk("cap15 good_b", 128'(b_good), 128'(0));
    chk("lat N valid_a", 128'(a_valid), 128'(0));
    tick();
    chk("lat N+1 valid_a", 128'(a_valid), 128'(0));
    tick();
    chk("lat N+2 valid_a", 128'(a_valid), 128'(1));
    chk("lat N+2 beat_a", 128'({a_last, a_keep, a_data}), 128'(mk_beat(8, 0, 1'b0)));
    drain_and_compare("cap");

    // Length limit on instance b (8 beats).
    clr_counters();
    send_frame(9, 11, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8, 12, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("len ovf_b", 128'(b_ovf), 128'(1));
    chk("len good_b", 128'(b_good), 128'(1));
    chk("len good_a", 128'(a_good), 128'(2));
    chk("len ovf_a", 128'(a_ovf), 128'(0));
    drain_and_compare("len");

    // Bursts of single-beat frames; 60 frames wrap the 16-entry pointers several times.
    clr_counters();
    rdy_rand = 1'b1;
    for (int bu = 0; bu < 5; bu++) begin
      for (int f = 0; f < 12; f++) send_frame(1, 20 + bu * 12 + f, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (80) tick();
    end
    drain_and_compare("b2b");
    chk("b2b good_a", 128'(a_good), 128'(60));
    chk("b2b good_b", 128'(b_good), 128'(60));
    chk("b2b ovf_a", 128'(a_ovf), 128'(0));

    // Reset with a committed frame queued and another in flight.
    rdy_force = 1'b0;
    send_frame(3, 90, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      {sAxiTlast, sAxiTkeep, sAxiTdata} = mk_beat(91, i, 1'b0);
      sAxiTvalid = 1'b1;
      tick();
    end
    sAxiTvalid = 1'b0;
    chk("prerst valid_a", 128'(a_valid), 128'(1));
    rst = 1'b1;
    #1;
    chk("midrst valid_a", 128'(a_valid), 128'(0));
    chk("midrst data_a", 128'({a_last, a_keep, a_data}), 128'(0));
    chk("midrst good_a", 128'(a_good), 128'(0));
    repeat (2) tick();
    rst = 1'b0;
    rdy_force = 1'b1;
    repeat (20) tick();
    chk("postrst empty_a", 128'(got_a.size()), 128'(0));
    chk("postrst empty_b", 128'(got_b.size()), 128'(0));
    send_frame(1, 93, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(2, 92, 1'b1, 1'b1, 1'b1, 1'b1);
    drain_and_compare("rst");
    chk("rst good_a", 128'(a_good), 128'(1));

    // Saturation: 65536 CRC-bad single-beat frames, alternating missing and failed CRC.
    clr_counters();
    for (int i = 0; i < 65536; i++) begin
      sAxiTvalid = 1'b1; sAxiTlast = 1'b1; sAxiTkeep = 8'hFF;
      sAxiTdata  = 64'(i); crcValid = 1'(i & 1); crcPass = 1'b0;
      tick();
    end
    sAxiTvalid = 1'b0; sAxiTlast = 1'b0; crcValid = 1'b0;
    chk("sat crc_a", 128'(a_crc), 128'(16'hFFFF));
    chk("sat crc_b", 128'(b_crc), 128'(16'hFFFF));
    chk("sat good_a", 128'(a_good), 128'(0));
    send_frame(1, 94, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat hold crc_a", 128'(a_crc), 128'(16'hFFFF));
    clearCounters = 1'b1;
    send_frame(1, 95, 1'b1, 1'b0, 1'b0, 1'b0);
    clearCounters = 1'b0;
    chk("clrinc crc_a", 128'(a_crc), 128'(0));
    chk("clrinc crc_b", 128'(b_crc), 128'(0));
    drain_and_compare("sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
